mips_writeback_unit: RTL and testbench

//  Writeback stage that drives both write ports of the dual-write-port register file.
//  It merges two in-order lanes from the MEM/WB pipeline register with results from the

---
 rtl/mips_writeback_unit.sv | 128 ++++++++++++
 tb/tb_mips_writeback_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mips_writeback_unit.sv
// mips_writeback_unit
//   Writeback stage feeding both write ports of the dual-write-port register file.
//   Two in-order lanes from MEM/WB have priority on the ports. Mult/div results are
//   queued in a small FIFO and drained into whichever ports the lanes leave idle.
//   All register-file outputs are registered (1-cycle latency).
// Ports
//   clk, rst                     clock, async active-high reset
//   l0_valid/l0_dest/l0_data     lane 0 (older) result
//   l1_valid/l1_dest/l1_data     lane 1 (younger) result
//   ld_valid/ld_dest/ld_data     mult/div result offer; ld_ready accepts
//   write_reg_1/2, write_data_1/2, signal_reg_write_1/2   regfile write ports
//   fifo_count                   occupied FIFO entries
module mips_writeback_unit #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          l0_valid,
    input  logic [4:0]                    l0_dest,
    input  logic [31:0]                   l0_data,
    input  logic                          l1_valid,
    input  logic [4:0]                    l1_dest,
    input  logic [31:0]                   l1_data,
    input  logic                          ld_valid,
    input  logic [4:0]                    ld_dest,
    input  logic [31:0]                   ld_data,
    output logic                          ld_ready,
    output logic [4:0]                    write_reg_1,
    output logic [31:0]                   write_data_1,
    output logic                          signal_reg_write_1,
    output logic [4:0]                    write_reg_2,
    output logic [31:0]                   write_data_2,
    output logic                          signal_reg_write_2,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [4:0]    mem_dest [FIFO_DEPTH];
    logic [31:0]   mem_data [FIFO_DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;

    logic          l0_live, l1_live, waw;
    logic          p1_lane, p1_fifo, p2_fifo, dup;
    logic [PW-1:0] nxt_ptr, p2_idx;
    logic [CW-1:0] pop_cnt;
    logic          push, store;
    logic          w1_en, w2_en;
    logic [4:0]    w1_reg, w2_reg;
    logic [31:0]   w1_data, w2_data;

    // Full FIFO blocks pushes even if a pop happens the same cycle
    assign ld_ready = (fifo_count < CW'(FIFO_DEPTH)) & ~rst;
    assign push     = ld_valid & ld_ready;
    assign store    = push & (ld_dest != 5'd0);
    assign nxt_ptr  = head_ptr + PW'(1);

    // Port selection: lanes first, FIFO entries fill idle ports oldest-first
    always_comb begin
        l0_live = l0_valid & (l0_dest != 5'd0);
        l1_live = l1_valid & (l1_dest != 5'd0);
        waw     = l0_live & l1_live & (l0_dest == l1_dest);
        p1_lane = l0_live & ~waw;
        p1_fifo = ~p1_lane & (fifo_count != CW'(0));
        p2_fifo = 1'b0;
        if (!l1_live) begin
            p2_fifo = p1_fifo ? (fifo_count >= CW'(2)) : (fifo_count != CW'(0));
        end
        p2_idx  = p1_fifo ? nxt_ptr : head_ptr;
        // Two popped entries to the same register: the younger one (port 2) wins
        dup     = p1_fifo & p2_fifo & (mem_dest[head_ptr] == mem_dest[nxt_ptr]);
        pop_cnt = CW'(p1_fifo) + CW'(p2_fifo);

        w1_en   = p1_lane | (p1_fifo & ~dup);
        w1_reg  = p1_lane ? l0_dest : mem_dest[head_ptr];
        w1_data = p1_lane ? l0_data : mem_data[head_ptr];
        w2_en   = l1_live | p2_fifo;
        w2_reg  = l1_live ? l1_dest : mem_dest[p2_idx];
        w2_data = l1_live ? l1_data : mem_data[p2_idx];
    end

    // FIFO storage; contents need no reset since occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (store) begin
            mem_dest[tail_ptr] <= ld_dest;
            mem_data[tail_ptr] <= ld_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr   <= '0;
            tail_ptr   <= '0;
            fifo_count <= '0;
        end else begin
            head_ptr   <= head_ptr + PW'(pop_cnt);
            if (store) tail_ptr <= tail_ptr + PW'(1);
            fifo_count <= fifo_count + CW'(store) - pop_cnt;
        end
    end

    // Registered write ports; idle ports hold address/data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_reg_1        <= '0;
            write_data_1       <= '0;
            signal_reg_write_1 <= 1'b0;
            write_reg_2        <= '0;
            write_data_2       <= '0;
            signal_reg_write_2 <= 1'b0;
        end else begin
            signal_reg_write_1 <= w1_en;
            signal_reg_write_2 <= w2_en;
            if (w1_en) begin
                write_reg_1  <= w1_reg;
                write_data_1 <= w1_data;
            end
            if (w2_en) begin
                write_reg_2  <= w2_reg;
                write_data_2 <= w2_data;
            end
        end
    end

endmodule

// File: tb/tb_mips_writeback_unit.sv
module tb_mips_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        l0_valid, l1_valid, ld_valid;
    logic [4:0]  l0_dest, l1_dest, ld_dest;
    logic [31:0] l0_data, l1_data, ld_data;
    logic        ld_ready;
    logic [4:0]  write_reg_1, write_reg_2;
    logic [31:0] write_data_1, write_data_2;
    logic        signal_reg_write_1, signal_reg_write_2;
    logic [2:0]  fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_writeback_unit #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .l0_valid(l0_valid), .l0_dest(l0_dest), .l0_data(l0_data),
        .l1_valid(l1_valid), .l1_dest(l1_dest), .l1_data(l1_data),
        .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data),
        .ld_ready(ld_ready),
        .write_reg_1(write_reg_1), .write_data_1(write_data_1),
        .signal_reg_write_1(signal_reg_write_1),
        .write_reg_2(write_reg_2), .write_data_2(write_data_2),
        .signal_reg_write_2(signal_reg_write_2),
        .fifo_count(fifo_count)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        l0_valid = 0; l0_dest = 0; l0_data = 0;
        l1_valid = 0; l1_dest = 0; l1_data = 0;
        ld_valid = 0; ld_dest = 0; ld_data = 0;
    endtask

    // Keep both ports busy with lane writes to r1/r2 so the FIFO only fills
    task automatic lanes_busy();
        l0_valid = 1; l0_dest = 5'd1; l0_data = 32'h100;
        l1_valid = 1; l1_dest = 5'd2; l1_data = 32'h200;
    endtask

    task automatic push(input logic [4:0] d, input logic [31:0] v);
        ld_valid = 1; ld_dest = d; ld_data = v;
        step();
        ld_valid = 0; ld_dest = 0; ld_data = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        #2;
        n_cmp++; if (signal_reg_write_1 !== 1'b0 || signal_reg_write_2 !== 1'b0) begin n_err++; $display("FAIL reset_en got %b%b exp 00", signal_reg_write_1, signal_reg_write_2); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", ld_ready); end
        step();
        rst = 0;
        step();
        n_cmp++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got %b exp 1", ld_ready); end
        // Fill FIFO with 3 entries, then reset mid-run
        lanes_busy();
        push(5'd10, 32'hA); push(5'd11, 32'hB); push(5'd12, 32'hC);
        n_cmp++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL prereset_count got %0d exp 3", fifo_count); end
        idle();
        rst = 1;
        #1;
        n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL midreset_count got %0d exp 0", fifo_count); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL midreset_ready got %b exp 0", ld_ready); end
        n_cmp++; if ({write_reg_1, write_data_1, signal_reg_write_1, write_reg_2, write_data_2, signal_reg_write_2} !== 76'd0) begin n_err++; $display("FAIL midreset_outputs got %h/%h/%b %h/%h/%b exp all 0", write_reg_1, write_data_1, signal_reg_write_1, write_reg_2, write_data_2, signal_reg_write_2); end
        step();
        rst = 0;
        step();
        n_cmp++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL postreset_ready got %b exp 1", ld_ready); end
        // Discarded entries must never be written
        n_cmp++; if (signal_reg_write_1 !== 1'b0 || signal_reg_write_2 !== 1'b0 || fifo_count !== 3'd0) begin n_err++; $display("FAIL postreset_drain got en %b%b cnt %0d exp 00 cnt 0", signal_reg_write_1, signal_reg_write_2, fifo_count); end
    endtask

    task automatic test_dual_lane();
        idle();
        l0_valid = 1; l0_dest = 5'd3; l0_data = 32'h11;
        l1_valid = 1; l1_dest = 5'd4; l1_data = 32'h22;
        step();
        idle();
        n_cmp++; if ({signal_reg_write_1, write_reg_1, write_data_1} !== {1'b1, 5'd3, 32'h11}) begin n_err++; $display("FAIL dual_p1 got %b/%0d/%h exp 1/3/11", signal_reg_write_1, write_reg_1, write_data_1); end
        n_cmp++; if ({signal_reg_write_2, write_reg_2, write_data_2} !== {1'b1, 5'd4, 32'h22}) begin n_err++; $display("FAIL dual_p2 got %b/%0d/%h exp 1/4/22", signal_reg_write_2, write_reg_2, write_data_2); end
        step();
        n_cmp++; if (signal_reg_write_1 !== 1'b0 || signal_reg_write_2 !== 1'b0 || write_reg_1 !== 5'd3 || write_data_2 !== 32'h22) begin n_err++; $display("FAIL idle_hold got en %b%b r1 %0d d2 %h exp 00 3 22", signal_reg_write_1, signal_reg_write_2, write_reg_1, write_data_2); end
    endtask

    task automatic test_same_dest();
        idle();
        l0_valid = 1; l0_dest = 5'd5; l0_data = 32'hAA;
        l1_valid = 1; l1_dest = 5'd5; l1_data = 32'hBB;
        step();
        idle();
        n_cmp++; if (signal_reg_write_1 !== 1'b0) begin n_err++; $display("FAIL waw_p1 got %b exp 0", signal_reg_write_1); end
        n_cmp++; if ({signal_reg_write_2, write_reg_2, write_data_2} !== {1'b1, 5'd5, 32'hBB}) begin n_err++; $display("FAIL waw_p2 got %b/%0d/%h exp 1/5/bb", signal_reg_write_2, write_reg_2, write_data_2); end
    endtask

    task automatic test_drain();
        idle();
        lanes_busy();
        push(5'd8, 32'd1); push(5'd9, 32'd2);
        n_cmp++; if (fifo_count !== 3'd2) begin n_err++; $display("FAIL drain_fill got %0d exp 2", fifo_count); end
        idle();
        step();
        n_cmp++; if ({signal_reg_write_1, write_reg_1, write_data_1} !== {1'b1, 5'd8, 32'd1}) begin n_err++; $display("FAIL drain_p1 got %b/%0d/%h exp 1/8/1", signal_reg_write_1, write_reg_1, write_data_1); end
        n_cmp++; if ({signal_reg_write_2, write_reg_2, write_data_2} !== {1'b1, 5'd9, 32'd2}) begin n_err++; $display("FAIL drain_p2 got %b/%0d/%h exp 1/9/2", signal_reg_write_2, write_reg_2, write_data_2); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL drain_count got %0d exp 0", fifo_count); end
    endtask

    task automatic test_backpressure();
        idle();
        lanes_busy();
        push(5'd12, 32'hC0); push(5'd13, 32'hC1); push(5'd14, 32'hC2); push(5'd15, 32'hC3);
        n_cmp++; if (fifo_count !== 3'd4 || ld_ready !== 1'b0) begin n_err++; $display("FAIL full got cnt %0d rdy %b exp 4 0", fifo_count, ld_ready); end
        // Offer while full: must be refused
        push(5'd16, 32'hDD);
        n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL full_refuse got %0d exp 4", fifo_count); end
        l1_valid = 0; l1_dest = 0;
        step();
        n_cmp++; if ({signal_reg_write_2, write_reg_2, write_data_2} !== {1'b1, 5'd12, 32'hC0}) begin n_err++; $display("FAIL bp_pop got %b/%0d/%h exp 1/12/c0", signal_reg_write_2, write_reg_2, write_data_2); end
        n_cmp++; if ({signal_reg_write_1, write_reg_1} !== {1'b1, 5'd1}) begin n_err++; $display("FAIL bp_lane got %b/%0d exp 1/1", signal_reg_write_1, write_reg_1); end
        n_cmp++; if (fifo_count !== 3'd3 || ld_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready got cnt %0d rdy %b exp 3 1", fifo_count, ld_ready); end
        idle();
        step();
        n_cmp++; if ({write_reg_1, write_data_1, write_reg_2, write_data_2} !== {5'd13, 32'hC1, 5'd14, 32'hC2}) begin n_err++; $display("FAIL bp_drain2 got %0d/%h %0d/%h exp 13/c1 14/c2", write_reg_1, write_data_1, write_reg_2, write_data_2); end
        step();
        n_cmp++; if ({signal_reg_write_1, write_reg_1, signal_reg_write_2, fifo_count} !== {1'b1, 5'd15, 1'b0, 3'd0}) begin n_err++; $display("FAIL bp_last got %b/%0d en2 %b cnt %0d exp 1/15 0 0", signal_reg_write_1, write_reg_1, signal_reg_write_2, fifo_count); end
    endtask

    task automatic test_dest_zero();
        idle();
        lanes_busy();
        push(5'd7, 32'd7);
        idle();
        l0_valid = 1; l0_dest = 5'd0; l0_data = 32'hDEAD;
        l1_valid = 1; l1_dest = 5'd6; l1_data = 32'h66;
        ld_valid = 1; ld_dest = 5'd0; ld_data = 32'h99;
        step();
        idle();
        n_cmp++; if ({signal_reg_write_1, write_reg_1, write_data_1} !== {1'b1, 5'd7, 32'd7}) begin n_err++; $display("FAIL dz_p1 got %b/%0d/%h exp 1/7/7", signal_reg_write_1, write_reg_1, write_data_1); end
        n_cmp++; if ({signal_reg_write_2, write_reg_2, write_data_2} !== {1'b1, 5'd6, 32'h66}) begin n_err++; $display("FAIL dz_p2 got %b/%0d/%h exp 1/6/66", signal_reg_write_2, write_reg_2, write_data_2); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL dz_count got %0d exp 0", fifo_count); end
        push(5'd0, 32'h55);
        n_cmp++; if (fifo_count !== 3'd0 || signal_reg_write_1 !== 1'b0 || signal_reg_write_2 !== 1'b0) begin n_err++; $display("FAIL dz_push got cnt %0d en %b%b exp 0 00", fifo_count, signal_reg_write_1, signal_reg_write_2); end
    endtask

    task automatic test_no_bypass();
        idle();
        push(5'd17, 32'h17);
        n_cmp++; if (fifo_count !== 3'd1 || signal_reg_write_1 !== 1'b0 || signal_reg_write_2 !== 1'b0) begin n_err++; $display("FAIL nobypass got cnt %0d en %b%b exp 1 00", fifo_count, signal_reg_write_1, signal_reg_write_2); end
        step();
        n_cmp++; if ({signal_reg_write_1, write_reg_1, write_data_1, signal_reg_write_2} !== {1'b1, 5'd17, 32'h17, 1'b0}) begin n_err++; $display("FAIL nobypass_pop got %b/%0d/%h en2 %b exp 1/17/17 0", signal_reg_write_1, write_reg_1, write_data_1, signal_reg_write_2); end
    endtask

    task automatic test_fifo_same_dest();
        idle();
        lanes_busy();
        push(5'd9, 32'hA1); push(5'd9, 32'hB2);
        idle();
        step();
        n_cmp++; if (signal_reg_write_1 !== 1'b0) begin n_err++; $display("FAIL fdup_p1 got %b exp 0", signal_reg_write_1); end
        n_cmp++; if ({signal_reg_write_2, write_reg_2, write_data_2, fifo_count} !== {1'b1, 5'd9, 32'hB2, 3'd0}) begin n_err++; $display("FAIL fdup_p2 got %b/%0d/%h cnt %0d exp 1/9/b2 0", signal_reg_write_2, write_reg_2, write_data_2, fifo_count); end
    endtask

    initial begin
        test_reset();
        test_dual_lane();
        test_same_dest();
        test_drain();
        test_backpressure();
        test_dest_zero();
        test_no_bypass();
        test_fifo_same_dest();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
